// File: rtl/synapse_accumulator.sv
// synapse_accumulator
// Presynaptic integration stage feeding the neuron's vpre input. Holds one
// programmable 8-bit weight per synapse, sums the weights of all spiking
// synapses over a window of WIN_LEN cycles, then publishes the sum saturated
// to 8 bits. The published value is held until the next publish.
//
// Ports:
//   clock        - rising-edge clock
//   reset        - synchronous, active-high; clears state, outputs and weights
//   enable       - run integration while high
//   spike_in     - presynaptic spikes, one bit per synapse
//   wr_en        - weight write strobe
//   wr_addr      - weight index
//   wr_data      - unsigned weight value
//   vpre         - last published window sum, saturated to 255
//   vpre_valid   - one-cycle pulse in the cycle vpre is updated
//   sat_flag     - last published window sum exceeded 255
//   window_count - number of windows published, wraps 255 -> 0
//   busy         - high while accumulating or publishing
module synapse_accumulator #(
  parameter int unsigned N_SYN   = 8,
  parameter int unsigned WIN_LEN = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [N_SYN-1:0]           spike_in,
  input  logic                       wr_en,
  input  logic [$clog2(N_SYN)-1:0]   wr_addr,
  input  logic [7:0]                 wr_data,
  output logic [7:0]                 vpre,
  output logic                       vpre_valid,
  output logic                       sat_flag,
  output logic [7:0]                 window_count,
  output logic                       busy
);

  localparam int unsigned AW     = $clog2(N_SYN);
  localparam int unsigned AXW    = AW + 1;
  localparam int unsigned CW     = 8 + AW;
  localparam int unsigned ACC_W  = 16;
  localparam int unsigned SUM_W  = ACC_W + 1;
  localparam int unsigned WCNT_W = 8;

  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(WIN_LEN - 1);
  localparam logic [AXW-1:0]    ADDR_LIM  = AXW'(N_SYN);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_PUBLISH
  } state_t;

  state_t state, next_state;

  logic [7:0]        weight [N_SYN];
  logic [ACC_W-1:0]  acc;
  logic [WCNT_W-1:0] wcnt;

  logic [CW-1:0]     csum;
  logic [SUM_W-1:0]  acc_sum;
  logic [ACC_W-1:0]  acc_sat;
  logic              acc_over;
  logic              wr_ok;

  // Control decoded from the FSM
  logic              do_accum;
  logic              do_publish;
  logic              do_clear;

  // Weighted sum of the synapses spiking this cycle (uses pre-write weights)
  always_comb begin
    csum = '0;
    for (int i = 0; i < N_SYN; i++) begin
      if (spike_in[i]) begin
        csum = csum + CW'(weight[i]);
      end
    end
  end

  // Accumulator add with saturation at 0xFFFF
  always_comb begin
    acc_sum  = SUM_W'(acc) + SUM_W'(csum);
    acc_sat  = acc_sum[ACC_W] ? {ACC_W{1'b1}} : acc_sum[ACC_W-1:0];
    acc_over = |acc[ACC_W-1:8];
  end

  // Writes beyond the synapse count are dropped
  always_comb begin
    wr_ok = wr_en && ({1'b0, wr_addr} < ADDR_LIM);
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and datapath control
  always_comb begin
    next_state = state;
    do_accum   = 1'b0;
    do_publish = 1'b0;
    do_clear   = 1'b0;
    case (state)
      ST_IDLE: begin
        do_clear = 1'b1;
        if (enable) begin
          next_state = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (!enable) begin
          // Partial window is discarded without publishing
          do_clear   = 1'b1;
          next_state = ST_IDLE;
        end else begin
          do_accum = 1'b1;
          if (wcnt == WCNT_LAST) begin
            next_state = ST_PUBLISH;
          end
        end
      end
      ST_PUBLISH: begin
        do_publish = 1'b1;
        do_clear   = 1'b1;
        next_state = enable ? ST_ACCUM : ST_IDLE;
      end
      default: begin
        do_clear   = 1'b1;
        next_state = ST_IDLE;
      end
    endcase
  end

  // Accumulator and window counter
  always_ff @(posedge clock) begin
    if (reset) begin
      acc  <= '0;
      wcnt <= '0;
    end else if (do_clear) begin
      acc  <= '0;
      wcnt <= '0;
    end else if (do_accum) begin
      acc  <= acc_sat;
      wcnt <= wcnt + WCNT_W'(1);
    end
  end

  // Weight table; writes are honoured in every state
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < N_SYN; i++) begin
        weight[i] <= '0;
      end
    end else if (wr_ok) begin
      weight[wr_addr] <= wr_data;
    end
  end

  // Published outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      vpre         <= '0;
      vpre_valid   <= 1'b0;
      sat_flag     <= 1'b0;
      window_count <= '0;
    end else begin
      vpre_valid <= do_publish;
      if (do_publish) begin
        vpre         <= acc_over ? 8'hFF : acc[7:0];
        sat_flag     <= acc_over;
        window_count <= window_count + 8'd1;
      end
    end
  end

  // Busy is a registered decode of the upcoming state
  always_ff @(posedge clock) begin
    if (reset) begin
      busy <= 1'b0;
    end else begin
      busy <= (next_state != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_synapse_accumulator.sv
// Testbench for synapse_accumulator: directed scenarios plus randomized
// stimulus, compared every cycle against a window-level reference model.
module tb_synapse_accumulator;

  localparam int unsigned N_SYN   = 8;
  localparam int unsigned WIN_LEN = 16;
  localparam int unsigned AW      = $clog2(N_SYN);

  logic              clock;
  logic              reset;
  logic              enable;
  logic [N_SYN-1:0]  spike_in;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [7:0]        wr_data;
  logic [7:0]        vpre;
  logic              vpre_valid;
  logic              sat_flag;
  logic [7:0]        window_count;
  logic              busy;

  synapse_accumulator #(
    .N_SYN   (N_SYN),
    .WIN_LEN (WIN_LEN)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .enable       (enable),
    .spike_in     (spike_in),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .vpre         (vpre),
    .vpre_valid   (vpre_valid),
    .sat_flag     (sat_flag),
    .window_count (window_count),
    .busy         (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  // Reference model: running flag, position in the window, integer sum
  bit running;
  bit publishing;
  int pos;
  int sum;
  int m_w [N_SYN];
  int m_vpre;
  int m_valid;
  int m_sat;
  int m_wc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Advance the model by one clock edge using the inputs present at that edge
  task automatic model_step();
    int cs;
    if (reset) begin
      running = 0; publishing = 0; pos = 0; sum = 0;
      m_vpre = 0; m_valid = 0; m_sat = 0; m_wc = 0;
      for (int i = 0; i < N_SYN; i++) m_w[i] = 0;
      return;
    end
    cs = 0;
    for (int i = 0; i < N_SYN; i++) if (spike_in[i]) cs += m_w[i];
    m_valid = 0;
    if (publishing) begin
      m_vpre  = (sum > 255) ? 255 : sum;
      m_sat   = (sum > 255) ? 1 : 0;
      m_wc    = (m_wc + 1) % 256;
      m_valid = 1;
      sum = 0; pos = 0;
      publishing = 0;
      running = enable;
    end else if (running) begin
      if (!enable) begin
        running = 0; sum = 0; pos = 0;
      end else begin
        sum += cs;
        if (sum > 65535) sum = 65535;
        pos++;
        if (pos == WIN_LEN) begin
          running = 0; publishing = 1;
        end
      end
    end else if (enable) begin
      running = 1; sum = 0; pos = 0;
    end
    if (wr_en && int'(wr_addr) < N_SYN) m_w[wr_addr] = int'(wr_data);
  endtask

  task automatic cycle();
    @(posedge clock);
    model_step();
    #1;
    cyc++;
    check("vpre", 32'(vpre), 32'(m_vpre));
    check("vpre_valid", 32'(vpre_valid), 32'(m_valid));
    check("sat_flag", 32'(sat_flag), 32'(m_sat));
    check("window_count", 32'(window_count), 32'(m_wc));
    check("busy", 32'(busy), 32'(running || publishing));
  endtask

  task automatic wr(input int a, input int d);
    wr_en = 1'b1; wr_addr = AW'(a); wr_data = 8'(d);
    cycle();
    wr_en = 1'b0;
  endtask

  // From IDLE: one cycle to enter the accumulate phase
  task automatic start();
    enable = 1'b1; spike_in = '0;
    cycle();
  endtask

  task automatic accum(input logic [N_SYN-1:0] s, input int n);
    for (int k = 0; k < n; k++) begin
      spike_in = s;
      cycle();
    end
  endtask

  // Publish cycle; spikes here must be ignored
  task automatic publish(input logic en_after);
    enable = en_after;
    spike_in = N_SYN'($urandom);
    cycle();
  endtask

  initial begin
    int t0, t1, pulses;
    reset = 1'b1; enable = 1'b0; spike_in = '0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    running = 0; publishing = 0; pos = 0; sum = 0;
    m_vpre = 0; m_valid = 0; m_sat = 0; m_wc = 0;
    for (int i = 0; i < N_SYN; i++) m_w[i] = 0;

    // Reset state
    cycle(); cycle();
    check("rst_vpre", 32'(vpre), 0);
    check("rst_busy", 32'(busy), 0);

    // Zero weights, random spikes, two windows
    reset = 1'b0; enable = 1'b1;
    pulses = 0; t0 = 0; t1 = 0;
    for (int k = 0; k < 200 && pulses < 2; k++) begin
      spike_in = N_SYN'($urandom);
      cycle();
      if (vpre_valid) begin
        if (pulses == 0) t0 = cyc; else t1 = cyc;
        pulses++;
      end
    end
    check("s1_pulses", 32'(pulses), 2);
    check("s1_spacing", 32'(t1 - t0), WIN_LEN + 1);
    check("s1_wc", 32'(window_count), 2);
    check("s1_vpre", 32'(vpre), 0);
    enable = 1'b0; cycle(); cycle();

    // Two weighted synapses spiking for 4 cycles; enable drops during publish
    wr(0, 10); wr(3, 5);
    start(); accum(8'h09, 4); accum(8'h00, WIN_LEN - 4); publish(1'b0);
    check("s2_vpre", 32'(vpre), 60);
    check("s2_sat", 32'(sat_flag), 0);
    check("s2_valid", 32'(vpre_valid), 1);
    check("s2_wc", 32'(window_count), 3);
    cycle();
    check("s2_idle_busy", 32'(busy), 0);

    // Full saturation, then an empty window
    for (int i = 0; i < N_SYN; i++) wr(i, 255);
    start(); accum(8'hFF, WIN_LEN); publish(1'b1);
    check("s3_vpre", 32'(vpre), 255);
    check("s3_sat", 32'(sat_flag), 1);
    accum(8'h00, WIN_LEN); publish(1'b0);
    check("s3_vpre0", 32'(vpre), 0);
    check("s3_sat0", 32'(sat_flag), 0);

    // Write in the same cycle as a spike: old weight then new weight
    wr(1, 2);
    start();
    wr_en = 1'b1; wr_addr = AW'(1); wr_data = 8'd7; spike_in = 8'h02;
    cycle();
    wr_en = 1'b0;
    accum(8'h02, 1); accum(8'h00, WIN_LEN - 2); publish(1'b0);
    check("s4_vpre", 32'(vpre), 9);

    // Drop enable mid-window: nothing published, vpre held
    wr(0, 4);
    start(); accum(8'h01, 10);
    enable = 1'b0; spike_in = 8'h01;
    cycle();
    check("s5_valid", 32'(vpre_valid), 0);
    for (int k = 0; k < 4; k++) begin
      spike_in = N_SYN'($urandom);
      cycle();
    end
    check("s5_hold", 32'(vpre), 9);
    check("s5_wc", 32'(window_count), 6);
    start(); accum(8'h01, 3); accum(8'h00, WIN_LEN - 3); publish(1'b0);
    check("s5_fresh", 32'(vpre), 12);

    // Reset mid-window with enable high
    wr(0, 33);
    start(); accum(8'h01, 1); accum(8'h00, WIN_LEN - 1); publish(1'b1);
    check("s6_vpre33", 32'(vpre), 33);
    accum(8'h01, 5);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    check("s6_rst_vpre", 32'(vpre), 0);
    check("s6_rst_wc", 32'(window_count), 0);
    check("s6_rst_busy", 32'(busy), 0);
    enable = 1'b0; cycle();
    start(); accum(8'hFF, WIN_LEN); publish(1'b1);
    check("s6_w_zero", 32'(vpre), 0);

    // Random traffic until window_count wraps
    pulses = 1;
    for (int k = 0; k < 256 * (WIN_LEN + 1) + 100 && pulses < 256; k++) begin
      spike_in = N_SYN'($urandom);
      wr_en    = ($urandom_range(0, 7) == 0);
      wr_addr  = AW'($urandom_range(0, N_SYN - 1));
      wr_data  = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom);
      cycle();
      if (vpre_valid) pulses++;
    end
    wr_en = 1'b0;
    check("wrap_pulses", 32'(pulses), 256);
    check("wrap_wc", 32'(window_count), 0);

    // Random traffic with enable drops and occasional resets
    for (int k = 0; k < 1500; k++) begin
      enable   = ($urandom_range(0, 31) != 0);
      reset    = ($urandom_range(0, 499) == 0);
      spike_in = N_SYN'($urandom);
      wr_en    = ($urandom_range(0, 5) == 0);
      wr_addr  = AW'($urandom_range(0, N_SYN - 1));
      wr_data  = 8'($urandom_range(0, 63));
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
